tt_seq_multiplier: RTL

//  Parametrised iterative shift-add multiplier; successor to the 4x4 combinational multiplier.

---
 rtl/tt_seq_multiplier.sv | 95 +++++++++
 1 files changed

// File: rtl/tt_seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per enabled clock, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are multiplied as magnitudes and the sign is applied when the result is written.
module tt_seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshakes: a transfer happens on an enabled edge where valid and ready are both high;
  // in_ready/out_valid depend only on state, never combinationally on the partner's signal.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_next;

  always_comb begin
    a_mag    = (signed_en && a[WIDTH-1]) ? -a : a;
    b_mag    = (signed_en && b[WIDTH-1]) ? -b : b;
    addend   = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    acc_next = acc + addend;
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (ena) begin
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              mcand  <= a_mag;
              mplier <= b_mag;
              neg    <= signed_en & (a[WIDTH-1] ^ b[WIDTH-1]);
              acc    <= '0;
              cnt    <= '0;
              state  <= RUN;
            end
          end
          RUN: begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              // A zero magnitude negates to zero, so no negative zero can appear.
              product <= neg ? -acc_next : acc_next;
              state   <= DONE;
            end
          end
          DONE: begin
            if (out_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
